// File: rtl/decode_stage_elastic_pkg.sv
// Shared types and field widths for the elastic decode stage.
// Payload bundle, immediate selectors and RV64I opcode constants.
package decode_pkg;

    localparam int ADDR_WIDTH  = 64;
    localparam int DATA_WIDTH  = 64;
    localparam int REG_ADDR_W  = 5;
    localparam int INSTR_WIDTH = 32;
    localparam int FUNC3_W     = 3;
    localparam int RSRC_W      = 3;
    localparam int ALUC_W      = 5;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OPIMMW = 7'b0011011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_OPW    = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_sel_e;

    // Writeback mux select carried with the op toward execute.
    localparam logic [RSRC_W-1:0] RES_ALU   = 3'd0;
    localparam logic [RSRC_W-1:0] RES_MEM   = 3'd1;
    localparam logic [RSRC_W-1:0] RES_PC4   = 3'd2;
    localparam logic [RSRC_W-1:0] RES_IMM   = 3'd3;
    localparam logic [RSRC_W-1:0] RES_PCIMM = 3'd4;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] pc_plus4;
        logic [DATA_WIDTH-1:0] imm;
        logic [DATA_WIDTH-1:0] rs1_data;
        logic [DATA_WIDTH-1:0] rs2_data;
        logic [REG_ADDR_W-1:0] rs1_addr;
        logic [REG_ADDR_W-1:0] rs2_addr;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [FUNC3_W-1:0]    func3;
        logic [RSRC_W-1:0]     result_src;
        logic [ALUC_W-1:0]     alu_control;
        logic                  mem_we;
        logic                  reg_we;
        logic                  alu_src;
        logic                  branch;
        logic                  jump;
        logic                  load_instr;
    } decode_payload_t;

endpackage

// File: rtl/decode_stage_elastic_if.sv
// Fetch/writeback/execute bundle of the elastic decode stage.
// slave is the stage's own view, master is the surrounding pipeline.
interface decode_stage_elastic_if;
    import decode_pkg::*;

    logic                   i_valid;
    logic                   o_ready;
    logic [INSTR_WIDTH-1:0] i_instruction;
    logic [ADDR_WIDTH-1:0]  i_pc;
    logic [ADDR_WIDTH-1:0]  i_pc_plus4;
    logic                   i_rd_we;
    logic [REG_ADDR_W-1:0]  i_rd_addr;
    logic [DATA_WIDTH-1:0]  i_rd_write_data;
    logic                   i_flush;
    logic                   o_valid;
    logic                   i_ready;
    logic [REG_ADDR_W-1:0]  o_rs1_addr_d;
    logic [REG_ADDR_W-1:0]  o_rs2_addr_d;
    logic [ADDR_WIDTH-1:0]  o_pc;
    logic [ADDR_WIDTH-1:0]  o_pc_plus4;
    logic [DATA_WIDTH-1:0]  o_imm_ext;
    logic [DATA_WIDTH-1:0]  o_rs1_data;
    logic [DATA_WIDTH-1:0]  o_rs2_data;
    logic [REG_ADDR_W-1:0]  o_rs1_addr;
    logic [REG_ADDR_W-1:0]  o_rs2_addr;
    logic [REG_ADDR_W-1:0]  o_rd_addr;
    logic [FUNC3_W-1:0]     o_func3;
    logic [RSRC_W-1:0]      o_result_src;
    logic [ALUC_W-1:0]      o_alu_control;
    logic                   o_mem_we;
    logic                   o_reg_we;
    logic                   o_alu_src;
    logic                   o_branch;
    logic                   o_jump;
    logic                   o_load_instr;

    modport slave (
        input  i_valid, i_instruction, i_pc, i_pc_plus4,
        input  i_rd_we, i_rd_addr, i_rd_write_data,
        input  i_flush, i_ready,
        output o_ready, o_valid, o_rs1_addr_d, o_rs2_addr_d,
        output o_pc, o_pc_plus4, o_imm_ext, o_rs1_data, o_rs2_data,
        output o_rs1_addr, o_rs2_addr, o_rd_addr, o_func3,
        output o_result_src, o_alu_control, o_mem_we, o_reg_we,
        output o_alu_src, o_branch, o_jump, o_load_instr
    );

    modport master (
        output i_valid, i_instruction, i_pc, i_pc_plus4,
        output i_rd_we, i_rd_addr, i_rd_write_data,
        output i_flush, i_ready,
        input  o_ready, o_valid, o_rs1_addr_d, o_rs2_addr_d,
        input  o_pc, o_pc_plus4, o_imm_ext, o_rs1_data, o_rs2_data,
        input  o_rs1_addr, o_rs2_addr, o_rd_addr, o_func3,
        input  o_result_src, o_alu_control, o_mem_we, o_reg_we,
        input  o_alu_src, o_branch, o_jump, o_load_instr
    );

endinterface

// File: rtl/decode_stage_elastic_dec.sv
// RV64I control decode and immediate extension.
// Purely combinational; instantiated by the decode stage top.
module control_unit
    import decode_pkg::*;
(
    input  logic [6:0]        i_opcode,
    input  logic [2:0]        i_func3,
    input  logic              i_func7_b5,
    output imm_sel_e          o_imm_sel,
    output logic [RSRC_W-1:0] o_result_src,
    output logic [ALUC_W-1:0] o_alu_control,
    output logic              o_mem_we,
    output logic              o_reg_we,
    output logic              o_alu_src,
    output logic              o_branch,
    output logic              o_jump,
    output logic              o_load_instr
);
    logic word_op;

    assign word_op = i_opcode[3];

    always_comb begin
        o_imm_sel     = IMM_NONE;
        o_result_src  = RES_ALU;
        o_alu_control = '0;
        o_mem_we      = 1'b0;
        o_reg_we      = 1'b0;
        o_alu_src     = 1'b0;
        o_branch      = 1'b0;
        o_jump        = 1'b0;
        o_load_instr  = 1'b0;
        unique case (i_opcode)
            OPC_LOAD: begin
                o_imm_sel    = IMM_I;
                o_result_src = RES_MEM;
                o_reg_we     = 1'b1;
                o_alu_src    = 1'b1;
                o_load_instr = 1'b1;
            end
            OPC_STORE: begin
                o_imm_sel = IMM_S;
                o_mem_we  = 1'b1;
                o_alu_src = 1'b1;
            end
            // Only shifts-right use funct7[5] among immediate ops.
            OPC_OPIMM, OPC_OPIMMW: begin
                o_imm_sel     = IMM_I;
                o_reg_we      = 1'b1;
                o_alu_src     = 1'b1;
                o_alu_control = {word_op,
                                 (i_func3 == 3'b101) & i_func7_b5,
                                 i_func3};
            end
            OPC_OP, OPC_OPW: begin
                o_reg_we      = 1'b1;
                o_alu_control = {word_op, i_func7_b5, i_func3};
            end
            OPC_BRANCH: begin
                o_imm_sel     = IMM_B;
                o_branch      = 1'b1;
                o_alu_control = {2'b01, i_func3};
            end
            OPC_LUI: begin
                o_imm_sel    = IMM_U;
                o_result_src = RES_IMM;
                o_reg_we     = 1'b1;
            end
            OPC_AUIPC: begin
                o_imm_sel    = IMM_U;
                o_result_src = RES_PCIMM;
                o_reg_we     = 1'b1;
            end
            OPC_JAL: begin
                o_imm_sel    = IMM_J;
                o_result_src = RES_PC4;
                o_reg_we     = 1'b1;
                o_jump       = 1'b1;
            end
            OPC_JALR: begin
                o_imm_sel    = IMM_I;
                o_result_src = RES_PC4;
                o_reg_we     = 1'b1;
                o_alu_src    = 1'b1;
                o_jump       = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

module extend_imm
    import decode_pkg::*;
(
    input  logic [INSTR_WIDTH-1:7] i_bits,
    input  imm_sel_e               i_sel,
    output logic [DATA_WIDTH-1:0]  o_imm
);
    logic s;

    assign s = i_bits[31];

    always_comb begin
        o_imm = '0;
        unique case (i_sel)
            IMM_I: o_imm = {{(DATA_WIDTH-12){s}}, i_bits[31:20]};
            IMM_S: o_imm = {{(DATA_WIDTH-12){s}}, i_bits[31:25],
                            i_bits[11:7]};
            IMM_B: o_imm = {{(DATA_WIDTH-12){s}}, i_bits[7],
                            i_bits[30:25], i_bits[11:8], 1'b0};
            IMM_U: o_imm = {{(DATA_WIDTH-32){s}}, i_bits[31:12],
                            12'b0};
            IMM_J: o_imm = {{(DATA_WIDTH-20){s}}, i_bits[19:12],
                            i_bits[20], i_bits[30:21], 1'b0};
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage_elastic_fifo.sv
// Decoded-op FIFO whose occupied entries track writeback,
// keeping buffered rs operands current while execute stalls.
module decode_op_fifo
    import decode_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  decode_payload_t       i_payload,
    input  logic                  i_wb_we,
    input  logic [REG_ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    output logic                  o_valid,
    output logic                  o_ready,
    output decode_payload_t       o_head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    decode_payload_t mem_q [DEPTH];
    decode_payload_t mem_d [DEPTH];
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   off;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        off   = '0;
        // i_wb_we already excludes x0.
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_q;
            if (i_wb_we && (CW'(off) < cnt_q)) begin
                if (mem_q[i].rs1_addr == i_wb_addr)
                    mem_d[i].rs1_data = i_wb_data;
                if (mem_q[i].rs2_addr == i_wb_addr)
                    mem_d[i].rs2_data = i_wb_data;
            end
        end
        if (i_flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (i_push) begin
                mem_d[wr_q] = i_payload;
                wr_d        = wr_q + 1'b1;
            end
            if (i_pop)
                rd_d = rd_q + 1'b1;
            cnt_d = cnt_q + CW'(i_push) - CW'(i_pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_valid = (cnt_q != '0);
    assign o_ready = (cnt_q != CW'(DEPTH));
    assign o_head  = mem_q[rd_q];

endmodule

// File: rtl/decode_stage_elastic.sv
// Elastic decode stage: decode, regfile read with bypass,
// and a snooping op FIFO between fetch and execute.
module decode_stage_elastic
    import decode_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input logic                   i_clk,
    input logic                   i_arst,
    decode_stage_elastic_if.slave bus
);
    localparam int NREGS = 2 ** REG_ADDR_W;

    logic [DATA_WIDTH-1:0] regs_q [NREGS];
    logic [REG_ADDR_W-1:0] rs1_a, rs2_a;
    logic [DATA_WIDTH-1:0] rs1_v, rs2_v;
    logic                  wb_en;
    imm_sel_e              imm_sel;
    logic [DATA_WIDTH-1:0] imm;
    logic [RSRC_W-1:0]     res_src;
    logic [ALUC_W-1:0]     alu_ctl;
    logic                  mem_we, reg_we, alu_src;
    logic                  branch, jump, load;
    logic                  push, pop;
    logic                  f_valid, f_ready;
    decode_payload_t       in_pl, head;

    assign rs1_a = bus.i_instruction[19:15];
    assign rs2_a = bus.i_instruction[24:20];
    assign wb_en = bus.i_rd_we && (bus.i_rd_addr != '0);

    assign bus.o_rs1_addr_d = rs1_a;
    assign bus.o_rs2_addr_d = rs2_a;

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
        end else if (wb_en) begin
            regs_q[bus.i_rd_addr] <= bus.i_rd_write_data;
        end
    end

    always_comb begin
        rs1_v = regs_q[rs1_a];
        rs2_v = regs_q[rs2_a];
        if (rs1_a == '0)
            rs1_v = '0;
        else if (wb_en && bus.i_rd_addr == rs1_a)
            rs1_v = bus.i_rd_write_data;
        if (rs2_a == '0)
            rs2_v = '0;
        else if (wb_en && bus.i_rd_addr == rs2_a)
            rs2_v = bus.i_rd_write_data;
    end

    control_unit u_ctrl (
        .i_opcode      (bus.i_instruction[6:0]),
        .i_func3       (bus.i_instruction[14:12]),
        .i_func7_b5    (bus.i_instruction[30]),
        .o_imm_sel     (imm_sel),
        .o_result_src  (res_src),
        .o_alu_control (alu_ctl),
        .o_mem_we      (mem_we),
        .o_reg_we      (reg_we),
        .o_alu_src     (alu_src),
        .o_branch      (branch),
        .o_jump        (jump),
        .o_load_instr  (load)
    );

    extend_imm u_imm (
        .i_bits (bus.i_instruction[INSTR_WIDTH-1:7]),
        .i_sel  (imm_sel),
        .o_imm  (imm)
    );

    always_comb begin
        in_pl             = '0;
        in_pl.pc          = bus.i_pc;
        in_pl.pc_plus4    = bus.i_pc_plus4;
        in_pl.imm         = imm;
        in_pl.rs1_data    = rs1_v;
        in_pl.rs2_data    = rs2_v;
        in_pl.rs1_addr    = rs1_a;
        in_pl.rs2_addr    = rs2_a;
        in_pl.rd_addr     = bus.i_instruction[11:7];
        in_pl.func3       = bus.i_instruction[14:12];
        in_pl.result_src  = res_src;
        in_pl.alu_control = alu_ctl;
        in_pl.mem_we      = mem_we;
        in_pl.reg_we      = reg_we;
        in_pl.alu_src     = alu_src;
        in_pl.branch      = branch;
        in_pl.jump        = jump;
        in_pl.load_instr  = load;
    end

    assign push = bus.i_valid && f_ready && !bus.i_flush;
    assign pop  = f_valid && bus.i_ready && !bus.i_flush;

    decode_op_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk     (i_clk),
        .i_arst    (i_arst),
        .i_flush   (bus.i_flush),
        .i_push    (push),
        .i_pop     (pop),
        .i_payload (in_pl),
        .i_wb_we   (wb_en),
        .i_wb_addr (bus.i_rd_addr),
        .i_wb_data (bus.i_rd_write_data),
        .o_valid   (f_valid),
        .o_ready   (f_ready),
        .o_head    (head)
    );

    assign bus.o_valid       = f_valid;
    assign bus.o_ready       = f_ready;
    assign bus.o_pc          = head.pc;
    assign bus.o_pc_plus4    = head.pc_plus4;
    assign bus.o_imm_ext     = head.imm;
    assign bus.o_rs1_data    = head.rs1_data;
    assign bus.o_rs2_data    = head.rs2_data;
    assign bus.o_rs1_addr    = head.rs1_addr;
    assign bus.o_rs2_addr    = head.rs2_addr;
    assign bus.o_rd_addr     = head.rd_addr;
    assign bus.o_func3       = head.func3;
    assign bus.o_result_src  = head.result_src;
    assign bus.o_alu_control = head.alu_control;
    assign bus.o_mem_we      = head.mem_we;
    assign bus.o_reg_we      = head.reg_we;
    assign bus.o_alu_src     = head.alu_src;
    assign bus.o_branch      = head.branch;
    assign bus.o_jump        = head.jump;
    assign bus.o_load_instr  = head.load_instr;

endmodule
